// File: rtl/ps2_rx_controller.sv
// PS/2 device-to-host receiver: deframes start/8 data LSB-first/odd parity/stop into data/valid/err.
// Latency: outputs update on the 4th clk edge after the stop-bit ps2_clk fall; no backpressure, a new frame overwrites.
// Optional frame timeout when PS2_TIMEOUT_EN is defined.
module ps2_rx_controller #(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       valid,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t     state, state_nxt;
  logic       clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
  logic       fall_q, bit_q;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       par_acc, par_err;
  logic       timeout;
  logic       start_en, shift_en, par_en, stop_en;

  // Registered edge pulse and matching data tap keep the two aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      fall_q   <= 1'b0;
      bit_q    <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_data;
      dat_s2   <= dat_s1;
      fall_q   <= clk_prev & ~clk_s2;
      bit_q    <= dat_s2;
    end
  end

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          to_cnt <= '0;
    else if (state == IDLE || fall_q) to_cnt <= '0;
    else if (!timeout)                to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = (to_cnt == TW'(TIMEOUT_CYCLES));
`else
  // Without the timeout feature the parameter has no effect.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = IDLE;
    end else if (fall_q) begin
      case (state)
        IDLE:    if (!bit_q) state_nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    start_en = 1'b0;
    shift_en = 1'b0;
    par_en   = 1'b0;
    stop_en  = 1'b0;
    if (fall_q && !timeout) begin
      start_en = (state == IDLE) && !bit_q;
      shift_en = (state == DATA);
      par_en   = (state == PARITY);
      stop_en  = (state == STOP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data    <= 8'h00;
      valid   <= 1'b0;
      err     <= 1'b0;
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
      par_acc <= 1'b0;
      par_err <= 1'b0;
    end else begin
      if (start_en) begin
        valid   <= 1'b0;
        err     <= 1'b0;
        bit_cnt <= 3'd0;
        par_acc <= 1'b0;
      end
      if (shift_en) begin
        shreg   <= {bit_q, shreg[7:1]};
        par_acc <= par_acc ^ bit_q;
        bit_cnt <= bit_cnt + 3'd1;
      end
      // Odd parity: data ones plus parity bit must be odd.
      if (par_en)
        par_err <= ~(par_acc ^ bit_q);
      if (stop_en) begin
        data  <= shreg;
        valid <= 1'b1;
        err   <= par_err | ~bit_q;
      end
      if (timeout) begin
        valid <= 1'b1;
        err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_controller.sv
// Directed bench for ps2_rx_controller: clean, error, reset and stall/timeout frames.
module tb_ps2_rx_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       err;
  int         vec = 0;
  int         mis = 0;

  ps2_rx_controller #(.TIMEOUT_CYCLES(100)) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .data     (data),
    .valid    (valid),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500us");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vec++;
    assert (obs === exp)
    else begin
      mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PS/2 bit: data set mid-high phase, 8-cycle low, 8-cycle high.
  task automatic send_bit(input logic b);
    @(negedge clk) ps2_data = b;
    cyc(4);
    ps2_clk = 1'b0;
    cyc(8);
    ps2_clk = 1'b1;
    cyc(4);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input string tag);
    send_bit(1'b0);
    chk({tag, "_vld_clr"}, {7'd0, valid}, 8'h00);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    @(negedge clk) ps2_data = stp;
    cyc(4);
    ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk({tag, "_vld_3rd"}, {7'd0, valid}, 8'h00);
    @(posedge clk);
    #1 chk({tag, "_vld_4th"}, {7'd0, valid}, 8'h01);
    cyc(6);
    ps2_clk = 1'b1;
    cyc(8);
  endtask

  initial begin
    cyc(2);
    chk("rst_data",  data,             8'h00);
    chk("rst_valid", {7'd0, valid},    8'h00);
    chk("rst_err",   {7'd0, err},      8'h00);
    @(negedge clk) rst = 1'b0;
    cyc(4);

    send_frame(8'hA5, 1'b1, 1'b1, "a5");
    chk("a5_data", data,          8'hA5);
    chk("a5_err",  {7'd0, err},   8'h00);

    send_frame(8'h00, 1'b1, 1'b1, "00");
    chk("00_data", data,          8'h00);
    chk("00_err",  {7'd0, err},   8'h00);
    send_frame(8'hFF, 1'b1, 1'b1, "ff");
    chk("ff_data", data,          8'hFF);
    chk("ff_err",  {7'd0, err},   8'h00);
    send_frame(8'h01, 1'b0, 1'b1, "01");
    chk("01_data", data,          8'h01);
    chk("01_err",  {7'd0, err},   8'h00);

    send_frame(8'h3C, 1'b0, 1'b1, "3c_par");
    chk("3c_data", data,          8'h3C);
    chk("3c_err",  {7'd0, err},   8'h01);

    send_frame(8'h5A, 1'b1, 1'b0, "5a_stop");
    chk("5a_data", data,          8'h5A);
    chk("5a_err",  {7'd0, err},   8'h01);

    // Line noise while idle: a falling edge with data high must change nothing.
    send_bit(1'b1);
    chk("noise_valid", {7'd0, valid}, 8'h01);
    chk("noise_data",  data,          8'h5A);

    // Abort a frame after four data bits with reset.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("mid_rst_data",  data,          8'h00);
    chk("mid_rst_valid", {7'd0, valid}, 8'h00);
    chk("mid_rst_err",   {7'd0, err},   8'h00);
    cyc(2);
    rst = 1'b0;
    cyc(4);
    send_frame(8'h81, 1'b1, 1'b1, "81");
    chk("81_data", data,          8'h81);
    chk("81_err",  {7'd0, err},   8'h00);

    // Stalled frame: start plus three data bits, then ps2_clk held high.
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    cyc(120);
`ifdef PS2_TIMEOUT_EN
    chk("to_valid", {7'd0, valid}, 8'h01);
    chk("to_err",   {7'd0, err},   8'h01);
    chk("to_data",  data,          8'h81);
`else
    chk("stall_valid", {7'd0, valid}, 8'h00);
    chk("stall_data",  data,          8'h81);
    @(negedge clk) rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(4);
`endif
    send_frame(8'h12, 1'b1, 1'b1, "12");
    chk("12_data", data,          8'h12);
    chk("12_err",  {7'd0, err},   8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule

// File: doc/ps2_rx_controller.md
# ps2_rx_controller

Receive-only PS/2 host interface. Samples the open-collector `ps2_clk`/`ps2_data` lines from a keyboard or mouse and deframes 11-bit device-to-host frames: start 0, 8 data bits LSB first, odd parity, stop 1. Presents each received byte with status flags to the peripheral bus wrapper. Runs entirely in the system clock domain; PS/2 inputs are treated as asynchronous.

## Interface
- `TIMEOUT_CYCLES`, 20000: max system-clock cycles allowed between consecutive `ps2_clk` falling edges inside a frame. Used only with `PS2_TIMEOUT_EN`.
- `clk`  in  1  system clock (100 MHz nominal); all logic on rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `ps2_clk`  in  1  PS/2 clock line, asynchronous, idles high.
- `ps2_data`  in  1  PS/2 data line, asynchronous.
- `data`  out  8  last received byte.
- `valid`  out  1  level; high when a frame has completed and `data`/`err` are current.
- `err`  out  1  level; high if the completed frame had a framing, parity or timeout error.

## Operation
- Both inputs pass through 2-FF synchronizers (reset to 1). A third register on synced clk detects falling edges (`prev=1, cur=0`). All bit sampling uses synced data at a detected falling edge.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on falling edge with data=0 (start bit): clear `valid`, `err`, bit counter, parity accumulator, go DATA. Falling edge with data=1: ignore and stay IDLE; outputs unchanged.
  - DATA: each falling edge shifts the bit into the MSB of an 8-bit shift register (right shift, so LSB-first arrival yields the correct byte) and XORs it into the parity accumulator. After the 8th bit (counter 7), go PARITY.
  - PARITY: sample the parity bit. Parity error if (XOR of 8 data bits) XOR parity bit != 1. Go STOP.
  - STOP: sample the stop bit. Load `data` from the shift register. Set `valid`=1. Set `err`=parity error OR (stop bit != 1). Go IDLE.
- `data`, `valid` and `err` hold until the next start bit is accepted or reset. `data` is also updated on error frames.
- Reset mid-frame: FSM to IDLE, counter/shift register cleared, outputs cleared. A partial frame in progress is discarded; the bit stream resynchronizes on the next start bit.
- Reset values: `data`=0x00, `valid`=0, `err`=0, FSM=IDLE.

## Timing
- Edge-to-action latency is 3 clk cycles (2 sync stages + edge register). `valid`/`err`/`data` change on the 4th rising `clk` edge after the `ps2_clk` falling edge of the stop bit.
- `ps2_clk` low and high phases must each be ≥3 clk cycles to be seen. Real PS/2 (10–16.7 kHz) far exceeds this.
- `ps2_data` must be stable ≥3 clk cycles before the `ps2_clk` falling edge.
- Throughput is one frame per 11 `ps2_clk` periods. No backpressure: an unread byte is overwritten by the next frame.

## Configuration
- `PS2_TIMEOUT_EN` defined: a cycle counter restarts at each detected falling edge while not IDLE. If it reaches `TIMEOUT_CYCLES`, the FSM returns to IDLE with `valid`=1, `err`=1 and `data` unchanged.
- `PS2_TIMEOUT_EN` undefined: no counter. An incomplete frame waits indefinitely and can be cleared only by reset.

## Test plan
- Send 0xA5 with parity 1, stop 1 -> `valid`=1, `data`=0xA5, `err`=0 within 4 cycles of the stop-bit falling edge.
- Back-to-back 0x00 (parity 1), 0xFF (parity 1), 0x01 (parity 0) -> each sets `data` correctly with `err`=0; `valid` drops at each new start bit.
- Send 0x3C with parity bit 0 -> `valid`=1, `err`=1, `data`=0x3C.
- Send 0x5A with correct parity and stop bit 0 -> `valid`=1, `err`=1.
- Assert `rst` after 4 data bits, release, then send 0x81 (parity 1) -> `data`=0x81, `err`=0. All outputs read 0 during reset.
- With `PS2_TIMEOUT_EN`, `TIMEOUT_CYCLES`=100: send start bit plus 3 data bits, then hold `ps2_clk` high for 120 cycles -> `valid`=1, `err`=1. A following full 0x12 frame is received cleanly.
